// File: rtl/imem_prefetch_buffer_if.sv
// imem_prefetch_buffer_if: core fetch port, backing-memory port and performance counters
interface imem_prefetch_buffer_if #(parameter int WIDTH = 32);
    logic             cpu_req;
    logic [WIDTH-1:0] cpu_addr;
    logic             flush;
    logic [WIDTH-1:0] cpu_data;
    logic             cpu_ready;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic [31:0]      hit_count;
    logic [31:0]      stall_count;
    modport slave (
        input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
        output cpu_data, cpu_ready, mem_req, mem_addr, hit_count, stall_count
    );
    modport master (
        output cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
        input  cpu_data, cpu_ready, mem_req, mem_addr, hit_count, stall_count
    );
endinterface

// File: rtl/imem_prefetch_buffer.sv
// imem_prefetch_buffer: two-entry instruction buffer with demand fetch and sequential next-word prefetch
module imem_prefetch_buffer #(
    parameter int WIDTH       = 32,
    parameter bit PREFETCH_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_prefetch_buffer_if.slave bus
);
    localparam int TW = WIDTH - 2;
    typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_t;
    state_t           r_state, w_next;
    logic [1:0]       r_valid;
    logic [TW-1:0]    r_tag [2];
    logic [WIDTH-1:0] r_data [2];
    logic             r_victim, r_drop, r_mem_req;
    logic [WIDTH-1:0] r_mem_addr;
    logic [31:0]      r_hit_cnt, r_stall_cnt;
    logic [TW-1:0]    w_tag, w_next_tag;
    logic [1:0]       w_hit, w_next_hit;
    logic             w_ready, w_victim, w_issue, w_done, w_fill;
    logic [WIDTH-1:0] w_issue_addr;

    assign w_tag         = bus.cpu_addr[WIDTH-1:2];
    assign w_next_tag    = w_tag + TW'(1);
    assign w_hit[0]      = bus.cpu_req && !bus.flush && r_valid[0] && r_tag[0] == w_tag;
    assign w_hit[1]      = bus.cpu_req && !bus.flush && r_valid[1] && r_tag[1] == w_tag;
    assign w_next_hit[0] = r_valid[0] && r_tag[0] == w_next_tag;
    assign w_next_hit[1] = r_valid[1] && r_tag[1] == w_next_tag;
    assign w_ready       = |w_hit;
    // Victim is the entry the latest hit did not touch; a double match falls back to entry 0
    assign w_victim      = w_ready ? (w_hit == 2'b01) : r_victim;
    assign w_done        = r_state != IDLE && bus.mem_ack;
    assign w_fill        = w_done && !bus.flush && !r_drop;

    assign bus.cpu_ready   = w_ready;
    assign bus.cpu_data    = w_hit[0] ? r_data[0] : w_hit[1] ? r_data[1] : '0;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.hit_count   = r_hit_cnt;
    assign bus.stall_count = r_stall_cnt;

    always_comb begin
        w_next       = r_state;
        w_issue      = 1'b0;
        w_issue_addr = {w_tag, 2'b00};
        case (r_state)
            IDLE: begin
                if (bus.cpu_req && !w_ready) begin
                    w_next  = DEMAND;
                    w_issue = 1'b1;
                end else if (PREFETCH_EN && w_ready && !(|w_next_hit)) begin
                    w_next       = PREFETCH;
                    w_issue      = 1'b1;
                    w_issue_addr = {w_next_tag, 2'b00};
                end
            end
            default: w_next = bus.mem_ack ? IDLE : r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_tag[0]    <= '0;
            r_tag[1]    <= '0;
            r_data[0]   <= '0;
            r_data[1]   <= '0;
            r_victim    <= 1'b0;
            r_drop      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_hit_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_victim    <= w_victim;
            r_hit_cnt   <= r_hit_cnt + {31'd0, w_ready && ~&r_hit_cnt};
            r_stall_cnt <= r_stall_cnt + {31'd0, bus.cpu_req && !w_ready && ~&r_stall_cnt};
            if (w_fill) begin
                r_valid[w_victim] <= 1'b1;
                r_tag[w_victim]   <= r_mem_addr[WIDTH-1:2];
                r_data[w_victim]  <= bus.mem_rdata;
            end
            if (bus.flush)
                r_valid <= '0;
            // A flush while waiting poisons the in-flight word; the ack still has to be consumed
            r_drop <= r_state != IDLE && !bus.mem_ack && (r_drop || bus.flush);
            if (w_issue) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_issue_addr;
            end else if (w_done) begin
                r_mem_req  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/imem_prefetch_buffer.md
IMEM_PREFETCH_BUFFER -- requirements
Module: imem_prefetch_buffer

Interface
REQ-001 Parameter: WIDTH, 32, data and address width in bits.
REQ-002 Parameter: PREFETCH_EN, 1, enables the sequential next-word prefetch.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; all state is cleared while low.
REQ-005 cpu_req  input  1  core presents a valid fetch address this cycle.
REQ-006 cpu_addr  input  WIDTH  core fetch byte address; bits [1:0] are ignored.
REQ-007 flush  input  1  invalidates all entries (branch redirect or self-modifying code).
REQ-008 cpu_data  output  WIDTH  instruction word for cpu_addr; 0 when cpu_ready=0.
REQ-009 cpu_ready  output  1  cpu_data is valid for cpu_addr this cycle (drives the core's imem_ready).
REQ-010 mem_req  output  1  registered request to the backing instruction memory.
REQ-011 mem_addr  output  WIDTH  registered word-aligned request address; bits [1:0]=0.
REQ-012 mem_ack  input  1  memory returns mem_rdata this cycle; ignored while mem_req=0.
REQ-013 mem_rdata  input  WIDTH  returned instruction word.
REQ-014 hit_count  output  32  cycles with cpu_req=1 and cpu_ready=1.
REQ-015 stall_count  output  32  cycles with cpu_req=1 and cpu_ready=0.

Function
REQ-016 The block shall hold two entries; each entry holds {valid, tag=addr[WIDTH-1:2], data}.
REQ-017 cpu_ready shall be combinational: 1 when cpu_req=1 and a valid entry tag equals cpu_addr[WIDTH-1:2]; cpu_data shall come from the matching entry.
REQ-018 FSM states: IDLE, DEMAND, PREFETCH.
REQ-019 IDLE, cpu_req=1 and miss -> DEMAND; mem_req=1 and mem_addr={cpu_addr[WIDTH-1:2],2'b00} from the next edge.
REQ-020 IDLE, cpu_req=1 and hit, PREFETCH_EN=1, (cpu_addr+4) absent from both entries -> PREFETCH, with mem_addr=(cpu_addr+4) word-aligned.
REQ-021 The +4 address shall wrap modulo 2^WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-022 In DEMAND and PREFETCH, mem_req and mem_addr shall stay stable until mem_ack=1; on the ack edge the block shall write the entry, drop mem_req, and return to IDLE.
REQ-023 Outstanding requests shall never be aborted; a cpu_addr change during PREFETCH waits for completion, then IDLE re-evaluates.
REQ-024 Replacement victim: the entry not matched by the most recent hit; on a tie or with no prior hit, entry 0.
REQ-025 A filled entry shall be readable (cpu_ready=1) in the cycle after the ack edge; miss latency = 1 + memory ack delay cycles.
REQ-026 flush=1 shall clear both valid bits on that edge; if a request is outstanding, its returning data shall be discarded (not written), and the FSM still waits for the ack.
REQ-027 Flush and ack on the same edge: flush wins, and the data is discarded.
REQ-028 cpu_ready shall be 0 in any cycle with flush=1.
REQ-029 hit_count and stall_count shall saturate at 0xFFFFFFFF.
REQ-030 The block shall never assert mem_req with mem_addr[1:0]!=0.

Reset
REQ-031 While reset=0: entries invalid, FSM=IDLE, mem_req=0, mem_addr=0, counters=0, cpu_ready=0, cpu_data=0.
REQ-032 Reset during DEMAND or PREFETCH shall drop the request; an ack arriving after release shall be ignored because mem_req=0.
REQ-033 The first request shall be evaluated on the first rising edge after reset returns high.

Verification
REQ-034 Cold miss: release reset, cpu_req=1, cpu_addr=0x00, memory ack 3 cycles after mem_req -> mem_addr=0x00, cpu_ready=1 with cpu_data=ROM[0], stall_count=4.
REQ-035 Prefetch: after the REQ-034 hit on 0x00 -> mem_addr=0x04 issued; cpu_addr=0x04 following completion -> cpu_ready=1 with no further mem_req.
REQ-036 Unaligned/wrap: cpu_addr=0xFFFFFFFE -> mem_addr=0xFFFFFFFC; next prefetch mem_addr=0x00000000.
REQ-037 Flush with request in flight: flush during PREFETCH of 0x08, ack 2 cycles later -> entry not written, cpu_addr=0x08 then misses and re-requests 0x08.
REQ-038 Reset mid-DEMAND: reset low for 1 cycle while mem_req=1, ack after release -> mem_req=0, counters=0, no entry valid.
REQ-039 Saturation: force stall_count to 0xFFFFFFFE, stall 3 cycles -> 0xFFFFFFFF held.
